multicycle_ctrl: RTL and testbench

Multi-cycle control unit for the RV32I core: a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port.
It generalises the single-cycle main decoder with a memory request/ready handshake, a configurable memory timeout, and an illegal-instruction/timeout trap state.
It sits between the instruction register and the shared datapath muxes, ALU, register file and memory interface.

---
 rtl/rv_ctrl_pkg.sv | 100 ++++++++++
 rtl/branch_cond.sv | 31 +++
 rtl/multicycle_ctrl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control unit:
// opcode and branch funct3 constants, the FSM state encoding, the
// datapath mux-select encodings, and the immediate-format decoder.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_AUIPC    = 4'd8,
        S_ALU_WB   = 4'd9,
        S_LUI      = 4'd10,
        S_BRANCH   = 4'd11,
        S_JALR     = 4'd12,
        S_JUMP     = 4'd13,
        S_LINK     = 4'd14,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;
    localparam logic [1:0] RES_IMM    = 2'b11;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Per-cycle control word; gated to zero as a whole during reset.
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] result_src;
        logic [2:0] load_ctrl;
        logic [1:0] store_ctrl;
        logic       trap;
        logic       instr_retired;
    } ctrl_t;

    function automatic logic [2:0] imm_src(input logic [6:0] opc);
        logic [2:0] sel;
        sel = IMM_I;
        case (opc)
            OP_STORE:         sel = IMM_S;
            OP_BRANCH:        sel = IMM_B;
            OP_JAL:           sel = IMM_J;
            OP_LUI, OP_AUIPC: sel = IMM_U;
            default:          sel = IMM_I;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluator (combinational).
// Ports:
//   funct3    in  3  branch type from IR[14:12]
//   alu_flags in  4  {N,Z,C,V} of the compare (rs1 - rs2)
//   taken     out 1  branch is taken
module branch_cond
    import rv_ctrl_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic [3:0] alu_flags,
    output logic       taken
);

    logic flag_n, flag_z, flag_c, flag_v;

    always_comb begin
        {flag_n, flag_z, flag_c, flag_v} = alu_flags;
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = flag_z;
            F3_BNE:  taken = ~flag_z;
            F3_BLT:  taken = flag_n ^ flag_v;
            F3_BGE:  taken = ~(flag_n ^ flag_v);
            // Subtract carry is "no borrow": set when rs1 >= rs2 unsigned.
            F3_BLTU: taken = ~flag_c;
            F3_BGEU: taken = flag_c;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control unit: Moore FSM sequencing fetch, decode,
// execute, memory and writeback over one shared ALU and memory port,
// with a memory ready handshake, optional memory timeout and a trap state.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   OPCode/funct3/funct75 instruction fields from the IR
//   ALUFlags             {N,Z,C,V} of the current ALU operation
//   memReady             memory completes the access this cycle
//   trapClear            leave TRAP
//   memReq..storeCtrl    datapath / memory control
//   trap, trapCause      trap indication and latched cause
//   instrRetired         pulse on the last cycle of each instruction
//   state                current state code (debug)
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MEM_HS      = 1,
    parameter int MEM_TIMEOUT = 0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] OPCode,
    input  logic [2:0] funct3,
    input  logic       funct75,
    input  logic [3:0] ALUFlags,
    input  logic       memReady,
    input  logic       trapClear,
    output logic       memReq,
    output logic       memWrite,
    output logic       adrSrc,
    output logic       irWrite,
    output logic       pcWrite,
    output logic       regWrite,
    output logic [1:0] aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] resultSrc,
    output logic [2:0] immSource,
    output logic [2:0] loadCtrl,
    output logic [1:0] storeCtrl,
    output logic       trap,
    output logic [1:0] trapCause,
    output logic       instrRetired,
    output logic [3:0] state
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       trap_cause_q, trap_cause_d;

    logic             ready;
    logic             taken;
    logic [CNT_W-1:0] wait_cnt_inc;
    logic             timeout_hit;
    ctrl_t            ctl;
    ctrl_t            ctl_out;
    // funct75 selects add/sub and srl/sra inside the ALU decoder, not here.
    logic             unused_funct75;

    branch_cond u_branch_cond (
        .funct3    (funct3),
        .alu_flags (ALUFlags),
        .taken     (taken)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            wait_cnt_q   <= '0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    always_comb begin
        unused_funct75 = funct75;
        ready        = (MEM_HS == 0) ? 1'b1 : memReady;
        wait_cnt_inc = wait_cnt_q + 1'b1;
        timeout_hit  = (MEM_TIMEOUT != 0) && (wait_cnt_inc == CNT_W'(MEM_TIMEOUT));

        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        // Counter is zero unless we stay in a wait state, so any entry
        // into FETCH/MEM_RD/MEM_WR starts from a cleared count.
        wait_cnt_d   = '0;
        ctl          = '0;

        case (state_q)
            S_FETCH: begin
                ctl.mem_req = 1'b1;
                ctl.adr_src = 1'b0;
                if (ready) begin
                    ctl.ir_write   = 1'b1;
                    ctl.pc_write   = 1'b1;
                    ctl.alu_src_a  = SRCA_PC;
                    ctl.alu_src_b  = SRCB_FOUR;
                    ctl.result_src = RES_ALU;
                    state_d        = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            S_DECODE: begin
                ctl.alu_src_a = SRCA_OLDPC;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
                case (OPCode)
                    OP_LOAD, OP_STORE: state_d = S_MEM_ADDR;
                    OP_RTYPE:          state_d = S_EXEC_R;
                    OP_ITYPE:          state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JUMP;
                    OP_JALR:           state_d = S_JALR;
                    OP_LUI:            state_d = S_LUI;
                    OP_AUIPC:          state_d = S_AUIPC;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
                state_d = (OPCode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                ctl.mem_req   = 1'b1;
                ctl.adr_src   = 1'b1;
                ctl.load_ctrl = funct3;
                if (ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            S_MEM_WB: begin
                ctl.result_src    = RES_MEM;
                ctl.reg_write     = 1'b1;
                ctl.load_ctrl     = funct3;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_MEM_WR: begin
                ctl.mem_req    = 1'b1;
                ctl.mem_write  = 1'b1;
                ctl.adr_src    = 1'b1;
                ctl.store_ctrl = funct3[1:0];
                if (ready) begin
                    ctl.instr_retired = 1'b1;
                    state_d           = S_FETCH;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_cnt_d = wait_cnt_inc;
                end
            end
            S_EXEC_R: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_RS2;
                ctl.alu_op    = ALUOP_FUNCT;
                state_d       = S_ALU_WB;
            end
            S_EXEC_I: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_FUNCT;
                state_d       = S_ALU_WB;
            end
            S_AUIPC: begin
                ctl.alu_src_a = SRCA_OLDPC;
                ctl.alu_src_b = SRCB_IMM;
                state_d       = S_ALU_WB;
            end
            S_ALU_WB: begin
                ctl.result_src    = RES_ALUOUT;
                ctl.reg_write     = 1'b1;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_LUI: begin
                ctl.result_src    = RES_IMM;
                ctl.reg_write     = 1'b1;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_BRANCH: begin
                ctl.alu_src_a     = SRCA_RS1;
                ctl.alu_src_b     = SRCB_RS2;
                ctl.alu_op        = ALUOP_SUB;
                ctl.result_src    = RES_ALUOUT;
                ctl.pc_write      = taken;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_JALR: begin
                ctl.alu_src_a = SRCA_RS1;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = ALUOP_ADD;
                state_d       = S_JUMP;
            end
            S_JUMP: begin
                ctl.pc_write   = 1'b1;
                ctl.result_src = RES_ALUOUT;
                state_d        = S_LINK;
            end
            S_LINK: begin
                ctl.alu_src_a     = SRCA_OLDPC;
                ctl.alu_src_b     = SRCB_FOUR;
                ctl.result_src    = RES_ALU;
                ctl.reg_write     = 1'b1;
                ctl.instr_retired = 1'b1;
                state_d           = S_FETCH;
            end
            S_TRAP: begin
                ctl.trap = 1'b1;
                if (trapClear) begin
                    trap_cause_d = CAUSE_NONE;
                    state_d      = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        ctl_out = rst ? '0 : ctl;
    end

    // Reset forces every output low in the same cycle, so an access in
    // flight loses memReq/memWrite immediately.
    always_comb begin
        memReq       = ctl_out.mem_req;
        memWrite     = ctl_out.mem_write;
        adrSrc       = ctl_out.adr_src;
        irWrite      = ctl_out.ir_write;
        pcWrite      = ctl_out.pc_write;
        regWrite     = ctl_out.reg_write;
        aluSrcA      = ctl_out.alu_src_a;
        aluSrcB      = ctl_out.alu_src_b;
        ALUOp        = ctl_out.alu_op;
        resultSrc    = ctl_out.result_src;
        loadCtrl     = ctl_out.load_ctrl;
        storeCtrl    = ctl_out.store_ctrl;
        trap         = ctl_out.trap;
        instrRetired = ctl_out.instr_retired;
        immSource    = rst ? '0 : imm_src(OPCode);
        trapCause    = rst ? '0 : trap_cause_q;
        state        = rst ? '0 : state_q;
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] OPCode;
    logic [2:0] funct3;
    logic       funct75;
    logic [3:0] ALUFlags;
    logic       memReady;
    logic       trapClear;
    logic       memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite;
    logic [1:0] aluSrcA, aluSrcB, ALUOp, resultSrc;
    logic [2:0] immSource, loadCtrl;
    logic [1:0] storeCtrl;
    logic       trap;
    logic [1:0] trapCause;
    logic       instrRetired;
    logic [3:0] state;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .MEM_HS      (1),
        .MEM_TIMEOUT (4),
        .CNT_W       (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .OPCode       (OPCode),
        .funct3       (funct3),
        .funct75      (funct75),
        .ALUFlags     (ALUFlags),
        .memReady     (memReady),
        .trapClear    (trapClear),
        .memReq       (memReq),
        .memWrite     (memWrite),
        .adrSrc       (adrSrc),
        .irWrite      (irWrite),
        .pcWrite      (pcWrite),
        .regWrite     (regWrite),
        .aluSrcA      (aluSrcA),
        .aluSrcB      (aluSrcB),
        .ALUOp        (ALUOp),
        .resultSrc    (resultSrc),
        .immSource    (immSource),
        .loadCtrl     (loadCtrl),
        .storeCtrl    (storeCtrl),
        .trap         (trap),
        .trapCause    (trapCause),
        .instrRetired (instrRetired),
        .state        (state)
    );

    localparam logic [6:0] OP_LD  = 7'b0000011, OP_ST  = 7'b0100011, OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011, OP_BR  = 7'b1100011, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JR  = 7'b1100111, OP_LUI = 7'b0110111, OP_AUI = 7'b0010111;
    localparam logic [6:0] OP_BAD = 7'b0000000;

    // ctl = {memReq,memWrite,adrSrc,irWrite,pcWrite,regWrite}
    // mux = {aluSrcA,aluSrcB,ALUOp,resultSrc}; tc = {trap,trapCause}
    typedef struct {
        logic       r;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [3:0] flags;
        logic       rdy;
        logic       clr;
        logic [3:0] st;
        logic [5:0] ctl;
        logic [7:0] mux;
        logic [2:0] ld;
        logic [1:0] sto;
        logic [2:0] tc;
        logic       ret;
        logic [2:0] imm;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void v(input logic r, input logic [6:0] opc, input logic [2:0] f3,
                              input logic [3:0] flags, input logic rdy, input logic clr,
                              input logic [3:0] st, input logic [5:0] ctl, input logic [7:0] mux,
                              input logic [2:0] ld, input logic [1:0] sto, input logic [2:0] tc,
                              input logic ret, input logic [2:0] imm);
        vec_t x;
        x.r = r; x.opc = opc; x.f3 = f3; x.flags = flags; x.rdy = rdy; x.clr = clr;
        x.st = st; x.ctl = ctl; x.mux = mux; x.ld = ld; x.sto = sto; x.tc = tc;
        x.ret = ret; x.imm = imm;
        vecs.push_back(x);
    endfunction

    // FETCH with memReady=1 followed by DECODE.
    function automatic void fd(input logic [6:0] opc, input logic [2:0] f3, input logic [2:0] imm);
        v(0, opc, f3, 4'b0, 1, 0, 4'd0, 6'b100110, 8'b00_10_00_10, 0, 0, 0, 0, imm);
        v(0, opc, f3, 4'b0, 1, 0, 4'd1, 6'b000000, 8'b01_01_00_00, 0, 0, 0, 0, imm);
    endfunction

    function automatic void br(input logic [2:0] f3, input logic [3:0] flags, input logic tk);
        fd(OP_BR, f3, 3'b010);
        v(0, OP_BR, f3, flags, 1, 0, 4'd11, tk ? 6'b000010 : 6'b000000, 8'b10_00_01_00,
          0, 0, 0, 1, 3'b010);
    endfunction

    task automatic lat(input logic [6:0] opc, input int want, input string nm);
        int  n;
        bit  seen;
        n = 0;
        seen = 0;
        OPCode = opc; funct3 = 3'b010; ALUFlags = 4'b0; memReady = 1'b1; trapClear = 1'b0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            #4;
            if (instrRetired) begin
                seen = 1;
                n = c;
            end
            @(posedge clk); #1;
        end
        total++;
        if (!seen || n != want) begin
            bad++;
            $display("FAIL latency_%s: got %0d cycles (retired=%0d), want %0d", nm, n, seen, want);
        end
    endtask

    initial begin
        logic [29:0] got, exp;
        rst = 1'b1; OPCode = OP_LUI; funct3 = 0; funct75 = 0; ALUFlags = 0;
        memReady = 1'b1; trapClear = 1'b0;

        // reset: everything zero, even immSource for a U-type opcode
        v(1, OP_LUI, 0, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 3'b000);
        v(1, OP_LUI, 0, 0, 1, 1, 4'd0, 0, 0, 0, 0, 0, 0, 3'b000);
        // ADD, trapClear in DECODE must be ignored
        v(0, OP_R, 0, 0, 1, 0, 4'd0, 6'b100110, 8'b00_10_00_10, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 1, 4'd1, 6'b000000, 8'b01_01_00_00, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd6, 6'b000000, 8'b10_00_10_00, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd9, 6'b000001, 8'b00_00_00_00, 0, 0, 0, 1, 3'b000);
        // LW with three wait cycles in MEM_RD
        fd(OP_LD, 3'b010, 3'b000);
        v(0, OP_LD, 3'b010, 0, 1, 0, 4'd2, 6'b000000, 8'b10_01_00_00, 0, 0, 0, 0, 3'b000);
        for (int i = 0; i < 3; i++)
            v(0, OP_LD, 3'b010, 0, 0, 0, 4'd3, 6'b101000, 0, 3'b010, 0, 0, 0, 3'b000);
        v(0, OP_LD, 3'b010, 0, 1, 0, 4'd3, 6'b101000, 0, 3'b010, 0, 0, 0, 3'b000);
        v(0, OP_LD, 3'b010, 0, 1, 0, 4'd4, 6'b000001, 8'b00_00_00_01, 3'b010, 0, 0, 1, 3'b000);
        // SW
        fd(OP_ST, 3'b010, 3'b001);
        v(0, OP_ST, 3'b010, 0, 1, 0, 4'd2, 6'b000000, 8'b10_01_00_00, 0, 0, 0, 0, 3'b001);
        v(0, OP_ST, 3'b010, 0, 1, 0, 4'd5, 6'b111000, 0, 0, 2'b10, 0, 1, 3'b001);
        // branches {N,Z,C,V}
        br(3'b001, 4'b0000, 1);  // BNE Z=0
        br(3'b001, 4'b0100, 0);  // BNE Z=1
        br(3'b000, 4'b0100, 1);  // BEQ
        br(3'b100, 4'b1000, 1);  // BLT N^V
        br(3'b100, 4'b1001, 0);
        br(3'b101, 4'b0001, 0);  // BGE
        br(3'b110, 4'b0010, 0);  // BLTU with C
        br(3'b111, 4'b0010, 1);  // BGEU
        br(3'b010, 4'b0100, 0);
        br(3'b011, 4'b1111, 0);
        // JAL, JALR
        fd(OP_JAL, 0, 3'b011);
        v(0, OP_JAL, 0, 0, 1, 0, 4'd13, 6'b000010, 0, 0, 0, 0, 0, 3'b011);
        v(0, OP_JAL, 0, 0, 1, 0, 4'd14, 6'b000001, 8'b01_10_00_10, 0, 0, 0, 1, 3'b011);
        fd(OP_JR, 0, 3'b000);
        v(0, OP_JR, 0, 0, 1, 0, 4'd12, 6'b000000, 8'b10_01_00_00, 0, 0, 0, 0, 3'b000);
        v(0, OP_JR, 0, 0, 1, 0, 4'd13, 6'b000010, 0, 0, 0, 0, 0, 3'b000);
        v(0, OP_JR, 0, 0, 1, 0, 4'd14, 6'b000001, 8'b01_10_00_10, 0, 0, 0, 1, 3'b000);
        // LUI, AUIPC, ADDI
        fd(OP_LUI, 0, 3'b100);
        v(0, OP_LUI, 0, 0, 1, 0, 4'd10, 6'b000001, 8'b00_00_00_11, 0, 0, 0, 1, 3'b100);
        fd(OP_AUI, 0, 3'b100);
        v(0, OP_AUI, 0, 0, 1, 0, 4'd8, 6'b000000, 8'b01_01_00_00, 0, 0, 0, 0, 3'b100);
        v(0, OP_AUI, 0, 0, 1, 0, 4'd9, 6'b000001, 0, 0, 0, 0, 1, 3'b100);
        fd(OP_I, 0, 3'b000);
        v(0, OP_I, 0, 0, 1, 0, 4'd7, 6'b000000, 8'b10_01_10_00, 0, 0, 0, 0, 3'b000);
        v(0, OP_I, 0, 0, 1, 0, 4'd9, 6'b000001, 0, 0, 0, 0, 1, 3'b000);
        // illegal opcode: trap held 5 cycles, memReady ignored, then clear
        fd(OP_BAD, 0, 3'b000);
        for (int i = 0; i < 5; i++)
            v(0, OP_BAD, 0, 0, 1, 0, 4'd15, 0, 0, 0, 0, 3'b101, 0, 3'b000);
        v(0, OP_BAD, 0, 0, 1, 1, 4'd15, 0, 0, 0, 0, 3'b101, 0, 3'b000);
        // FETCH timeout: 4 waiting cycles then TRAP cause 10
        for (int i = 0; i < 4; i++)
            v(0, OP_R, 0, 0, 0, 0, 4'd0, 6'b100000, 0, 0, 0, 3'b000, 0, 3'b000);
        v(0, OP_R, 0, 0, 0, 0, 4'd15, 0, 0, 0, 0, 3'b110, 0, 3'b000);
        v(0, OP_R, 0, 0, 0, 1, 4'd15, 0, 0, 0, 0, 3'b110, 0, 3'b000);
        // memReady on the 4th waiting cycle wins over timeout
        for (int i = 0; i < 3; i++)
            v(0, OP_R, 0, 0, 0, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd0, 6'b100110, 8'b00_10_00_10, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd1, 6'b000000, 8'b01_01_00_00, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd6, 6'b000000, 8'b10_00_10_00, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd9, 6'b000001, 0, 0, 0, 0, 1, 3'b000);
        // MEM_RD timeout
        fd(OP_LD, 3'b100, 3'b000);
        v(0, OP_LD, 3'b100, 0, 1, 0, 4'd2, 6'b000000, 8'b10_01_00_00, 0, 0, 0, 0, 3'b000);
        for (int i = 0; i < 4; i++)
            v(0, OP_LD, 3'b100, 0, 0, 0, 4'd3, 6'b101000, 0, 3'b100, 0, 0, 0, 3'b000);
        v(0, OP_LD, 3'b100, 0, 0, 1, 4'd15, 0, 0, 0, 0, 3'b110, 0, 3'b000);
        // reset mid-wait in FETCH; counter must restart from zero
        v(0, OP_R, 0, 0, 0, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 0, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 0, 3'b000);
        v(1, OP_R, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 3'b000);
        v(1, OP_R, 0, 0, 0, 0, 4'd0, 0, 0, 0, 0, 0, 0, 3'b000);
        for (int i = 0; i < 3; i++)
            v(0, OP_R, 0, 0, 0, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd0, 6'b100110, 8'b00_10_00_10, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd1, 6'b000000, 8'b01_01_00_00, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd6, 6'b000000, 8'b10_00_10_00, 0, 0, 0, 0, 3'b000);
        v(0, OP_R, 0, 0, 1, 0, 4'd9, 6'b000001, 0, 0, 0, 0, 1, 3'b000);
        // reset during a store wait: no write, no retire
        fd(OP_ST, 3'b001, 3'b001);
        v(0, OP_ST, 3'b001, 0, 1, 0, 4'd2, 6'b000000, 8'b10_01_00_00, 0, 0, 0, 0, 3'b001);
        v(0, OP_ST, 3'b001, 0, 0, 0, 4'd5, 6'b111000, 0, 0, 2'b01, 0, 0, 3'b001);
        v(1, OP_ST, 3'b001, 0, 1, 0, 4'd0, 0, 0, 0, 0, 0, 0, 3'b000);
        v(0, OP_ST, 3'b001, 0, 0, 0, 4'd0, 6'b100000, 0, 0, 0, 0, 0, 3'b001);

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            rst = vecs[i].r; OPCode = vecs[i].opc; funct3 = vecs[i].f3;
            ALUFlags = vecs[i].flags; memReady = vecs[i].rdy; trapClear = vecs[i].clr;
            #4;
            got = {state, memReq, memWrite, adrSrc, irWrite, pcWrite, regWrite,
                   aluSrcA, aluSrcB, ALUOp, resultSrc, loadCtrl, storeCtrl,
                   trap, trapCause, instrRetired, immSource};
            exp = {vecs[i].st, vecs[i].ctl, vecs[i].mux, vecs[i].ld, vecs[i].sto,
                   vecs[i].tc, vecs[i].ret, vecs[i].imm};
            total++;
            if (got !== exp) begin
                bad++;
                $display("FAIL vec%0d: got st=%0d ctl=%b mux=%b ld=%b sto=%b tc=%b ret=%b imm=%b, want st=%0d ctl=%b mux=%b ld=%b sto=%b tc=%b ret=%b imm=%b",
                         i, got[29:26], got[25:20], got[19:12], got[11:9], got[8:7], got[6:4], got[3], got[2:0],
                         exp[29:26], exp[25:20], exp[19:12], exp[11:9], exp[8:7], exp[6:4], exp[3], exp[2:0]);
            end
            @(posedge clk); #1;
        end

        lat(OP_LUI, 3, "lui");
        lat(OP_R,   4, "add");
        lat(OP_LD,  5, "lw");
        lat(OP_ST,  4, "sw");
        lat(OP_BR,  3, "branch");
        lat(OP_JAL, 4, "jal");
        lat(OP_JR,  5, "jalr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
